time_keeper: RTL

- Downstream consumer of the 1 Hz divider output, clocked by the same 4 kHz system clock.
- Detects each rising edge of clk_1hz and advances an HH:MM:SS time-of-day count held as BCD digits.
- Provides a button-driven set mode for hours and minutes.
- Digit outputs feed the seven-segment display multiplexer.

---
 rtl/time_keeper_pkg.sv | 31 +++
 rtl/time_keeper_rise_detect.sv | 11 +
 rtl/time_keeper.sv | 80 ++++++++
 3 files changed

// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg: shared mode encodings, BCD limits and BCD increment helpers.
package time_keeper_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;
  localparam logic [3:0] SEC_MAX_TENS = 4'd5;
  localparam bcd2_t BCD59    = {SEC_MAX_TENS, 4'd9};
  localparam bcd2_t HR24_MAX = 8'h23;
  localparam bcd2_t HR12_MAX = 8'h12;
  localparam bcd2_t HR12_MIN = 8'h01;
  function automatic bcd2_t bcd_step(bcd2_t v);
    return (v.ones == 4'd9) ? {v.tens + 4'd1, 4'd0} : {v.tens, v.ones + 4'd1};
  endfunction
  function automatic bcd2_t bcd_inc60(bcd2_t v);
    return (v == BCD59) ? 8'h00 : bcd_step(v);
  endfunction
  function automatic bcd2_t hr_inc(bcd2_t v, logic h24);
    return h24 ? ((v == HR24_MAX) ? 8'h00 : bcd_step(v))
               : ((v == HR12_MAX) ? HR12_MIN : bcd_step(v));
  endfunction
  // In 12-hour format the meridiem flips when 11 rolls over to 12.
  function automatic logic hr_pm_flip(bcd2_t v, logic h24);
    return !h24 && (v == 8'h11);
  endfunction
endpackage

// File: rtl/time_keeper_rise_detect.sv
// rise_detect: one-cycle pulse on a rising edge of a level synchronous to clk_4kHz.
module rise_detect (
  input  logic clk_4kHz,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic hist;
  always_ff @(posedge clk_4kHz) hist <= in;
  assign pulse = in & ~hist & ~reset;
endmodule

// File: rtl/time_keeper.sv
// time_keeper: BCD HH:MM:SS clock advanced by 1 Hz ticks, with button-driven hour/minute set mode.
import time_keeper_pkg::*;
module time_keeper #(
  parameter bit H24 = 1'b1
) (
  input  logic       clk_4kHz,
  input  logic       reset,
  input  logic       clk_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic [1:0] set_mode,
  output logic       blink_hr,
  output logic       blink_min
);
  localparam bcd2_t HR_RST = H24 ? 8'h00 : HR12_MAX;
  mode_t state, state_n;
  bcd2_t hr, mn, sc, hr_n, mn_n, sc_n;
  logic pm_r, pm_n, tick, mode_p, inc_p, inc_hr, inc_mn;
  rise_detect u_tick (.clk_4kHz(clk_4kHz), .reset(reset), .in(clk_1hz),  .pulse(tick));
  rise_detect u_mode (.clk_4kHz(clk_4kHz), .reset(reset), .in(btn_mode), .pulse(mode_p));
  rise_detect u_inc  (.clk_4kHz(clk_4kHz), .reset(reset), .in(btn_inc),  .pulse(inc_p));
  always_ff @(posedge clk_4kHz)
    if (reset) state <= RUN;
    else state <= state_n;
  always_comb
    state_n = !mode_p          ? state   :
              (state == RUN)    ? SET_HR  :
              (state == SET_HR) ? SET_MIN : RUN;
  // A mode press in the same cycle as an inc press swallows the inc.
  assign inc_hr = inc_p && !mode_p && (state == SET_HR);
  assign inc_mn = inc_p && !mode_p && (state == SET_MIN);
  always_comb begin
    sc_n = sc;
    mn_n = mn;
    hr_n = hr;
    pm_n = pm_r;
    if (tick && state == RUN) begin
      sc_n = bcd_inc60(sc);
      if (sc == BCD59) mn_n = bcd_inc60(mn);
      if (sc == BCD59 && mn == BCD59) begin
        hr_n = hr_inc(hr, H24);
        pm_n = pm_r ^ hr_pm_flip(hr, H24);
      end
    end
    if (mode_p && state == SET_MIN) sc_n = 8'h00;
    if (inc_hr) begin
      hr_n = hr_inc(hr, H24);
      pm_n = pm_r ^ hr_pm_flip(hr, H24);
    end
    if (inc_mn) mn_n = bcd_inc60(mn);
  end
  always_ff @(posedge clk_4kHz)
    if (reset) begin
      hr   <= HR_RST;
      mn   <= 8'h00;
      sc   <= 8'h00;
      pm_r <= 1'b0;
    end else begin
      hr   <= hr_n;
      mn   <= mn_n;
      sc   <= sc_n;
      pm_r <= pm_n;
    end
  always_comb begin
    {hr_tens, hr_ones}   = hr;
    {min_tens, min_ones} = mn;
    {sec_tens, sec_ones} = sc;
    pm        = H24 ? 1'b0 : pm_r;
    set_mode  = state;
    blink_hr  = (state == SET_HR) & clk_1hz;
    blink_min = (state == SET_MIN) & clk_1hz;
  end
endmodule
